ctxt_buffer: RTL and testbench

CTXT_BUFFER -- requirements
Module: ctxt_buffer

---
 rtl/caesar_pkg.sv | 17 +
 rtl/ctxt_buffer.sv | 118 +++++++++++
 tb/tb_ctxt_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/caesar_pkg.sv
// Shared definitions for the Caesar cipher datapath: character type and the
// reserved NULL character the cipher stage emits for rejected input.
`timescale 1ns/1ps
package caesar_pkg;

  // One ciphertext character.
  typedef logic [7:0] char_t;

  // The cipher stage emits NULL_CHAR for characters it rejects.
  localparam char_t NULL_CHAR = 8'h00;

  // True when a character is the rejected-character marker.
  function automatic logic is_null(input char_t c);
    return (c == NULL_CHAR);
  endfunction

endpackage : caesar_pkg

// File: rtl/ctxt_buffer.sv
// Ciphertext output buffer: a first-word-fall-through FIFO between the cipher
// stage and the consumer. It stores non-NULL characters, counts NULL
// characters in a saturating counter, and flags dropped characters with a
// sticky overflow bit.
//
// Handshake: a character leaves the FIFO on a rising edge where
// out_valid && out_ready. out_valid is simply !empty, and out_char and
// out_valid hold steady while out_valid && !out_ready. The input side has no
// back-pressure: in_valid marks a character every cycle it is high, and a
// non-NULL character that finds the FIFO full with no pop in the same cycle
// is dropped and recorded in overflow.
`timescale 1ns/1ps
module ctxt_buffer
  import caesar_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  char_t                    in_char,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output char_t                    out_char,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [CNT_W-1:0]         null_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Storage; contents are never reset and are masked from out_char when empty.
  char_t              r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_null_cnt;

  logic               w_empty;
  logic               w_full;
  logic               w_is_null;
  logic               w_push_req;
  logic               w_null_in;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_null_sat;

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_W'(DEPTH));
  assign w_is_null  = is_null(in_char);
  assign w_push_req = in_valid && !w_is_null;
  assign w_null_in  = in_valid && w_is_null;
  // A pop needs data present; an empty FIFO never pops even with out_ready.
  assign w_pop      = !w_empty && out_ready;
  // When full, a same-cycle pop frees the slot the push is about to take.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_null_sat = (r_null_cnt == {CNT_W{1'b1}});

  // Write the storage array on an accepted push; a clear cycle discards input.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr_ptr] <= in_char;
    end
  end

  // Pointer, occupancy and status state; clear overrides all traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_null_cnt <= '0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_null_cnt <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_null_in && !w_null_sat) begin
        r_null_cnt <= r_null_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_char  = w_empty ? NULL_CHAR : r_mem[r_rd_ptr];
  assign level     = r_level;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign null_cnt  = r_null_cnt;

endmodule : ctxt_buffer

// File: tb/tb_ctxt_buffer.sv
// Directed bench for ctxt_buffer (DEPTH=8, CNT_W=8) with hand-computed
// expected values.
`timescale 1ns/1ps
module tb_ctxt_buffer;
  import caesar_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  char_t                  in_char;
  logic                   clear;
  logic                   out_valid;
  logic                   out_ready;
  char_t                  out_char;
  logic [$clog2(DEPTH):0] level;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  logic [CNT_W-1:0]       null_cnt;

  int n_vec;
  int n_err;
  logic [7:0] exp_q[$];

  ctxt_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .null_cnt  (null_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are stable 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Push one character with out_ready held low
  task automatic push_hold(input logic [7:0] c);
    in_valid  = 1'b1;
    in_char   = c;
    out_ready = 1'b0;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_level"},    32'(level),     32'd0);
    check_val({tag, "_empty"},    32'(empty),     32'd1);
    check_val({tag, "_full"},     32'(full),      32'd0);
    check_val({tag, "_valid"},    32'(out_valid), 32'd0);
    check_val({tag, "_char"},     32'(out_char),  32'h00);
    check_val({tag, "_overflow"}, 32'(overflow),  32'd0);
    check_val({tag, "_nullcnt"},  32'(null_cnt),  32'd0);
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] e;
    logic       saw_valid;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    clear     = 1'b0;
    out_ready = 1'b0;

    // ---- Reset state ----
    #12;
    check_reset_state("reset");
    step();
    rst_n = 1'b1;
    step();

    // ---- 'K','h','o' streaming with out_ready=1 ----
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_char   = "K";
    step();
    check_val("khO_k_char",  32'(out_char),  32'h4B);
    check_val("khO_k_valid", 32'(out_valid), 32'd1);
    check_val("khO_k_level", 32'(level),     32'd1);
    in_char = "h";
    step();
    check_val("khO_h_char",  32'(out_char), 32'h68);
    check_val("khO_h_level", 32'(level),    32'd1);
    in_char = "o";
    step();
    check_val("khO_o_char",  32'(out_char), 32'h6F);
    check_val("khO_o_level", 32'(level),    32'd1);
    in_valid = 1'b0;
    step();
    check_val("khO_end_empty", 32'(empty),    32'd1);
    check_val("khO_end_char",  32'(out_char), 32'h00);

    // ---- Fill to full, overflow on 9th, drain in order ----
    for (int i = 0; i < 8; i++) begin
      c = 8'h41 + 8'(i);
      push_hold(c);
    end
    check_val("fill_full",     32'(full),     32'd1);
    check_val("fill_level",    32'(level),    32'd8);
    check_val("fill_overflow", 32'(overflow), 32'd0);
    check_val("fill_head",     32'(out_char), 32'h41);
    push_hold("I");
    check_val("ovf_flag",  32'(overflow), 32'd1);
    check_val("ovf_level", 32'(level),    32'd8);
    check_val("ovf_head",  32'(out_char), 32'h41);
    step();
    check_val("stall_char",  32'(out_char),  32'h41);
    check_val("stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = 8'h41 + 8'(i);
      check_val($sformatf("drain%0d", i), 32'(out_char), 32'(e));
      step();
    end
    check_val("drain_empty",    32'(empty),    32'd1);
    check_val("drain_overflow", 32'(overflow), 32'd1);

    // ---- Full FIFO, push and pop in the same cycle ----
    out_ready = 1'b0;
    do_clear();
    check_val("clr_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      c = 8'h61 + 8'(i);
      exp_q.push_back(c);
      push_hold(c);
    end
    check_val("pp_head", 32'(out_char), 32'h61);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h58);
    in_valid  = 1'b1;
    in_char   = "X";
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("pp_level",    32'(level),    32'd8);
    check_val("pp_overflow", 32'(overflow), 32'd0);
    check_val("pp_full",     32'(full),     32'd1);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      check_val($sformatf("pp_drain%0d", i), 32'(out_char), 32'(e));
      step();
    end
    check_val("pp_empty", 32'(empty), 32'd1);

    // ---- 300 NULL inputs: counter saturates, nothing stored ----
    do_clear();
    saw_valid = 1'b0;
    in_valid  = 1'b1;
    in_char   = NULL_CHAR;
    for (int i = 0; i < 300; i++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
      if (i == 9)   check_val("null_cnt10",  32'(null_cnt), 32'd10);
      if (i == 254) check_val("null_cnt255", 32'(null_cnt), 32'd255);
    end
    in_valid = 1'b0;
    check_val("null_sat",   32'(null_cnt),  32'd255);
    check_val("null_level", 32'(level),     32'd0);
    check_val("null_never_valid", 32'(saw_valid), 32'd0);

    // ---- Clear together with a push at level=5, overflow=1 ----
    for (int i = 0; i < 9; i++) begin
      c = 8'h70 + 8'(i);
      push_hold(c);
    end
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    check_val("pre_clr_level",    32'(level),    32'd5);
    check_val("pre_clr_overflow", 32'(overflow), 32'd1);
    check_val("pre_clr_head",     32'(out_char), 32'h73);
    in_valid = 1'b1;
    in_char  = "Q";
    do_clear();
    in_valid = 1'b0;
    check_reset_state("clr_push");
    in_valid = 1'b1;
    in_char  = NULL_CHAR;
    do_clear();
    check_val("clr_null_cnt", 32'(null_cnt), 32'd0);
    step();
    in_valid = 1'b0;
    check_val("post_clr_null_cnt", 32'(null_cnt), 32'd1);

    // ---- Asynchronous reset mid-stream ----
    push_hold("r");
    push_hold("s");
    push_hold("t");
    check_val("pre_rst_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    in_valid  = 1'b1;
    in_char   = "Z";
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check_val("post_rst_char",  32'(out_char),  32'h5A);
    check_val("post_rst_level", 32'(level),     32'd1);
    check_val("post_rst_valid", 32'(out_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ctxt_buffer
